// File: rtl/t08_mem_arbiter.sv
// t08 shared-bus arbiter and sequencer.
// Serialises core data, core fetch and DMA read requests onto one
// strobe/busy bus and returns registered read data with a one-cycle ack.
//
// Handshakes:
//   requester side - req is a level held until the matching one-cycle ack;
//                    the request fields are captured once, at grant.
//   bus side       - a one-cycle bus_read/bus_write strobe starts a transfer.
//                    The bus manager raises bus_busy while working, and the
//                    first cycle bus_busy is low again carries bus_rdata.
//                    If bus_busy never rises within TIMEOUT cycles, the
//                    transfer completes with err.
module t08_mem_arbiter #(
   parameter int STARVE_LIMIT = 16,
   parameter int TIMEOUT      = 8
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_sel,
   output logic        d_ack,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   input  logic        x_req,
   input  logic [31:0] x_addr,
   output logic        x_ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic        bus_read,
   output logic        bus_write,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_sel,
   input  logic [31:0] bus_rdata,
   input  logic        bus_busy,
   output logic        freeze
);

   // FSM encoding; state is kept as a plain named register so checkers can bind to it
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   // owner ids
   localparam logic [1:0] OWN_D = 2'd0;
   localparam logic [1:0] OWN_I = 2'd1;
   localparam logic [1:0] OWN_X = 2'd2;

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] STARVE_MAX  = SW'(STARVE_LIMIT);
   localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT);

   logic [1:0]    state;
   logic [1:0]    owner;
   logic          we_q;
   logic          seen_busy;
   logic [TW-1:0] tcnt;
   logic [TW-1:0] tcnt_nxt;
   logic [SW-1:0] starve_cnt;

   logic          any_req;
   logic          grant;
   logic          x_first;
   logic [1:0]    win_own;
   logic [31:0]   win_addr;
   logic [31:0]   win_wdata;
   logic [3:0]    win_sel;
   logic          win_we;

   assign any_req  = d_req | i_req | x_req;
   assign grant    = (state == S_IDLE) && any_req && !bus_busy;
   assign x_first  = (starve_cnt == STARVE_MAX);
   assign tcnt_nxt = tcnt + TW'(1);

   // Winner selection: d > i > x, with a starved DMA port jumping the queue
   always_comb begin
      win_own = OWN_X;
      if (x_first && x_req) begin
         win_own = OWN_X;
      end else if (d_req) begin
         win_own = OWN_D;
      end else if (i_req) begin
         win_own = OWN_I;
      end else begin
         win_own = OWN_X;
      end
   end

   // Request fields of the winner; fetch and DMA are full-word reads
   always_comb begin
      win_addr  = x_addr;
      win_wdata = 32'h0;
      win_sel   = 4'hF;
      win_we    = 1'b0;
      case (win_own)
         OWN_D: begin
            win_addr  = d_addr;
            win_wdata = d_we ? d_wdata : 32'h0;
            win_sel   = d_sel;
            win_we    = d_we;
         end
         OWN_I: begin
            win_addr  = i_addr;
         end
         default: begin
            win_addr  = x_addr;
         end
      endcase
   end

   // Capture the granted request; these hold steady for the whole transfer
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         owner     <= OWN_D;
         we_q      <= 1'b0;
         bus_addr  <= 32'h0;
         bus_wdata <= 32'h0;
         bus_sel   <= 4'h0;
      end else if (grant) begin
         owner     <= win_own;
         we_q      <= win_we;
         bus_addr  <= win_addr;
         bus_wdata <= win_wdata;
         bus_sel   <= win_sel;
      end
   end

   // Transaction sequencer: strobe, wait for busy to rise and fall (or time out), respond
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= S_IDLE;
         seen_busy <= 1'b0;
         tcnt      <= '0;
         rdata     <= 32'h0;
         err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant) begin
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               seen_busy <= 1'b0;
               tcnt      <= '0;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               if (bus_busy) begin
                  seen_busy <= 1'b1;
               end
               if (seen_busy && !bus_busy) begin
                  rdata <= we_q ? 32'h0 : bus_rdata;
                  err   <= 1'b0;
                  state <= S_RESP;
               end else if (!seen_busy && !bus_busy) begin
                  tcnt <= tcnt_nxt;
                  if (tcnt_nxt == TIMEOUT_MAX) begin
                     rdata <= 32'h0;
                     err   <= 1'b1;
                     state <= S_RESP;
                  end
               end
            end
            default: begin
               // err accompanies the ack only; rdata is left as last returned
               err   <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // DMA starvation counter: counts ungranted cycles of x_req, saturating
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         starve_cnt <= '0;
      end else if (!x_req) begin
         starve_cnt <= '0;
      end else if (grant && (win_own == OWN_X)) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end

   // Strobes, acks and core freeze decoded from registered state
   always_comb begin
      bus_write = (state == S_ISSUE) &&  we_q;
      bus_read  = (state == S_ISSUE) && !we_q;
      d_ack     = (state == S_RESP) && (owner == OWN_D);
      i_ack     = (state == S_RESP) && (owner == OWN_I);
      x_ack     = (state == S_RESP) && (owner == OWN_X);
      freeze    = (d_req & ~d_ack) | (i_req & ~i_ack);
   end

   // At most one ack and one strobe at a time
   a_ack_onehot : assert property (@(posedge clk) disable iff (!nrst)
      $onehot0({d_ack, i_ack, x_ack}));
   a_strobe_onehot : assert property (@(posedge clk) disable iff (!nrst)
      !(bus_read && bus_write));
   // ISSUE never lasts more than one cycle
   a_issue_once : assert property (@(posedge clk) disable iff (!nrst)
      (state == S_ISSUE) |=> (state == S_WAIT));

endmodule

// File: tb/tb_t08_mem_arbiter.sv
// Bench for t08_mem_arbiter: table of simultaneous-request vectors plus
// hand-written sequences for reset, latency, starvation, timeout and busy
// blocking. A small bus responder answers strobes; a scoreboard queue holds
// the expected {owner, err, rdata} of every ack in order.
module tb_t08_mem_arbiter;

   localparam logic [1:0] OWN_D = 2'd0;
   localparam logic [1:0] OWN_I = 2'd1;
   localparam logic [1:0] OWN_X = 2'd2;

   logic        clk;
   logic        nrst;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_sel;
   logic        d_ack;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic        x_req;
   logic [31:0] x_addr;
   logic        x_ack;
   logic [31:0] rdata;
   logic        err;
   logic        bus_read, bus_write;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_sel;
   logic [31:0] bus_rdata;
   logic        bus_busy;
   logic        freeze;

   // requester levels: a request is outstanding while issued != acked, or held
   int   d_issued, d_acked, i_issued, i_acked, x_issued, x_acked;
   logic d_hold, i_hold;
   assign d_req = d_hold | (d_issued != d_acked);
   assign i_req = i_hold | (i_issued != i_acked);
   assign x_req = (x_issued != x_acked);

   logic        busy_resp, force_busy;
   logic [31:0] resp_addr;
   int          lat;
   assign bus_busy = busy_resp | force_busy;

   int n_checks, n_err;
   logic [34:0] exp_q[$];

   t08_mem_arbiter dut (
      .clk(clk), .nrst(nrst),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_sel(d_sel), .d_ack(d_ack),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
      .x_req(x_req), .x_addr(x_addr), .x_ack(x_ack),
      .rdata(rdata), .err(err),
      .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_rdata(bus_rdata),
      .bus_busy(bus_busy), .freeze(freeze)
   );

   // clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'h5A5A_00FF);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   // driver tasks: set fields, raise the request, push the expected ack
   task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s);
      d_we = we; d_addr = a; d_wdata = wd; d_sel = s;
      d_issued++;
      exp_q.push_back({OWN_D, (lat == 0), (we || lat == 0) ? 32'h0 : rd_model(a)});
   endtask

   task automatic req_i(input logic [31:0] a);
      i_addr = a;
      i_issued++;
      exp_q.push_back({OWN_I, (lat == 0), (lat == 0) ? 32'h0 : rd_model(a)});
   endtask

   task automatic req_x(input logic [31:0] a);
      x_addr = a;
      x_issued++;
      exp_q.push_back({OWN_X, (lat == 0), (lat == 0) ? 32'h0 : rd_model(a)});
   endtask

   task automatic wait_strobe(input string name, output logic ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus_read || bus_write) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now(name);
   endtask

   task automatic wait_done(input string name);
      logic done;
      done = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy_resp) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) fail_now(name);
      repeat (2) @(negedge clk);
   endtask

   // bus responder: busy for lat cycles starting the cycle after the strobe
   initial begin
      busy_resp = 1'b0;
      bus_rdata = 32'h0;
      resp_addr = 32'h0;
      forever begin
         @(negedge clk);
         if ((bus_read || bus_write) && lat > 0) begin
            resp_addr = bus_addr;
            @(negedge clk);
            busy_resp = 1'b1;
            repeat (lat) @(negedge clk);
            busy_resp = 1'b0;
            bus_rdata = rd_model(resp_addr);
         end
      end
   end

   // monitor / scoreboard: samples 1 time unit after the active edge
   initial begin
      logic [34:0] e;
      logic [1:0]  own;
      forever begin
         @(posedge clk);
         #1;
         chk("freeze_eq", freeze, (d_req & ~d_ack) | (i_req & ~i_ack));
         if (d_ack || i_ack || x_ack) begin
            chk("ack_onehot", $onehot({d_ack, i_ack, x_ack}), 1);
            own = x_ack ? OWN_X : (i_ack ? OWN_I : OWN_D);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_ack: owner %0d rdata %0h err %0b", own, rdata, err);
            end else begin
               e = exp_q.pop_front();
               chk("ack_owner_err_rdata", {own, err, rdata}, e);
            end
            if (d_ack && d_acked != d_issued) d_acked++;
            if (i_ack && i_acked != i_issued) i_acked++;
            if (x_ack && x_acked != x_issued) x_acked++;
         end
      end
   end

   typedef struct {
      logic        dreq;
      logic        dwe;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic [3:0]  dsel;
      logic        ireq;
      logic [31:0] iaddr;
      logic        xreq;
      logic [31:0] xaddr;
      int          vlat;
      logic        ewr;
      logic [31:0] eaddr;
      logic [31:0] ewdata;
      logic [3:0]  esel;
      logic        efrz;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic ok;
      int   cnt;

      vecs[0] = '{1'b1, 1'b1, 32'h800, 32'h1234, 4'h3, 1'b1, 32'h44, 1'b1, 32'h2000, 1,
                  1'b1, 32'h800, 32'h1234, 4'h3, 1'b1};
      vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 32'h3000, 2,
                  1'b0, 32'h3000, 32'h0, 4'hF, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h80, 1'b1, 32'h3100, 3,
                  1'b0, 32'h80, 32'h0, 4'hF, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 32'h900, 32'hFFFF_FFFF, 4'hC, 1'b0, 32'h0, 1'b1, 32'h3200, 1,
                  1'b0, 32'h900, 32'h0, 4'hC, 1'b1};
      vecs[4] = '{1'b1, 1'b1, 32'hA00, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0, 2,
                  1'b1, 32'hA00, 32'hCAFE_F00D, 4'hF, 1'b1};

      n_checks = 0; n_err = 0;
      d_issued = 0; d_acked = 0; i_issued = 0; i_acked = 0; x_issued = 0; x_acked = 0;
      d_hold = 1'b0; i_hold = 1'b0;
      d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_sel = 4'h0;
      i_addr = 32'h0; x_addr = 32'h0;
      force_busy = 1'b0;
      lat = 1;

      // reset state
      nrst = 1'b0;
      #1;
      chk("reset_acks", {d_ack, i_ack, x_ack}, 0);
      chk("reset_strobes", {bus_read, bus_write}, 0);
      chk("reset_err_rdata", {err, rdata}, 0);
      chk("reset_bus_fields", {bus_addr, bus_wdata}, 0);
      chk("reset_bus_sel", bus_sel, 0);
      chk("reset_freeze", freeze, 0);
      chk("reset_state", dut.state, 0);
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      repeat (2) @(negedge clk);

      // single fetch: strobe at t+1, ack at t+4
      lat = 1;
      req_i(32'h40);
      @(negedge clk);
      chk("fetch_strobe_read", {bus_read, bus_write}, 2'b10);
      chk("fetch_bus_addr", bus_addr, 32'h40);
      chk("fetch_bus_sel", bus_sel, 4'hF);
      repeat (2) @(negedge clk);
      chk("fetch_no_early_ack", i_ack, 0);
      @(negedge clk);
      chk("fetch_ack_t4", i_ack, 1);
      chk("fetch_rdata", rdata, 32'hDEADBEEF);
      chk("fetch_err", err, 0);
      wait_done("fetch_done");

      // table of simultaneous-request vectors
      for (int v = 0; v < 5; v++) begin
         lat = vecs[v].vlat;
         if (vecs[v].dreq) req_d(vecs[v].dwe, vecs[v].daddr, vecs[v].dwdata, vecs[v].dsel);
         if (vecs[v].ireq) req_i(vecs[v].iaddr);
         if (vecs[v].xreq) req_x(vecs[v].xaddr);
         wait_strobe("vec_strobe", ok);
         if (ok) begin
            chk("vec_first_write", {bus_write, bus_read}, {vecs[v].ewr, ~vecs[v].ewr});
            chk("vec_first_addr", bus_addr, vecs[v].eaddr);
            chk("vec_first_wdata", bus_wdata, vecs[v].ewdata);
            chk("vec_first_sel", bus_sel, vecs[v].esel);
            chk("vec_freeze", freeze, vecs[v].efrz);
         end
         wait_done("vec_done");
      end

      // busy-blocked grant: no strobe while bus_busy held, strobe the cycle after it falls
      lat = 1;
      force_busy = 1'b1;
      req_d(1'b1, 32'hB00, 32'h5555_AAAA, 4'h1);
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus_read || bus_write) cnt++;
      end
      chk("blocked_no_strobe", cnt, 0);
      force_busy = 1'b0;
      @(negedge clk);
      chk("blocked_strobe_next", {bus_write, bus_addr}, {1'b1, 32'hB00});
      wait_done("blocked_done");

      // timeout: bus_busy never rises, ack with err exactly 9 cycles after the strobe
      lat = 0;
      req_d(1'b0, 32'h100, 32'h0, 4'hF);
      wait_strobe("timeout_strobe", ok);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         cnt++;
         if (d_ack) break;
      end
      chk("timeout_latency", cnt, 9);
      chk("timeout_err_rdata", {err, rdata}, {1'b1, 32'h0});
      wait_done("timeout_done");
      lat = 2;
      req_i(32'h180);
      wait_done("after_timeout_done");

      // starvation: d and i re-request continuously, x promoted after 16 cycles
      lat = 1;
      d_we = 1'b0; d_addr = 32'h600; d_sel = 4'hF;
      i_addr = 32'h650;
      d_hold = 1'b1; i_hold = 1'b1;
      for (int k = 0; k < 4; k++) exp_q.push_back({OWN_D, 1'b0, rd_model(32'h600)});
      req_x(32'h7000);
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (x_acked == x_issued) begin
            ok = 1'b1;
            break;
         end
      end
      d_hold = 1'b0; i_hold = 1'b0;
      if (!ok) fail_now("starve_x_grant");
      wait_done("starve_done");

      // reset mid-WAIT: transaction abandoned, no ack afterwards
      lat = 6;
      d_we = 1'b0; d_addr = 32'h500; d_sel = 4'hF;
      d_issued++;
      wait_strobe("rst_strobe", ok);
      repeat (2) @(negedge clk);
      chk("rst_pre_state_wait", dut.state, 2);
      nrst = 1'b0;
      #1;
      chk("rst_mid_acks", {d_ack, i_ack, x_ack}, 0);
      chk("rst_mid_strobes_err", {bus_read, bus_write, err}, 0);
      chk("rst_mid_state", dut.state, 0);
      d_issued = d_acked;
      @(negedge clk);
      nrst = 1'b1;
      cnt = 0;
      repeat (15) begin
         @(negedge clk);
         if (d_ack) cnt++;
      end
      chk("rst_no_ack_after", cnt, 0);
      wait_done("rst_done");

      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
